// File: rtl/data_mem_ext.sv
// Byte-addressable data memory with byte/half/word stores, sign/zero-extended
// loads and a fully pipelined read path of READ_LAT clock edges.
module data_mem_ext #(
  parameter int DEPTH    = 1024,
  parameter int READ_LAT = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        m_read,
  input  logic        m_write,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] d_in,
  output logic [31:0] d_out,
  output logic        rd_valid,
  output logic        err
);

  localparam int AW = $clog2(DEPTH);

  typedef struct packed {
    logic [1:0] off;
    logic [1:0] size;
    logic       uns;
  } meta_t;

  function automatic logic [31:0] load_extend(input logic [31:0] w, input meta_t m);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (m.off)
      2'b00:   b = w[7:0];
      2'b01:   b = w[15:8];
      2'b10:   b = w[23:16];
      2'b11:   b = w[31:24];
      default: b = 8'h00;
    endcase
    if (m.off[1]) begin
      h = w[31:16];
    end else begin
      h = w[15:0];
    end
    case (m.size)
      2'b00:   r = m.uns ? {24'h00_0000, b} : {{24{b[7]}}, b};
      2'b01:   r = m.uns ? {16'h0000, h} : {{16{h[15]}}, h};
      default: r = w;
    endcase
    return r;
  endfunction

  logic [1:0]    size_s;
  logic [AW-1:0] idx_s;
  logic          bad_s;
  logic          ld_acc_s;
  logic          st_acc_s;
  logic          err_d;
  logic [3:0]    be_s;
  logic [31:0]   wdata_s;
  meta_t         meta_d;

  logic [31:0]                mem_q [DEPTH];
  logic [READ_LAT-1:0]        vld_q;
  logic [READ_LAT-1:0][31:0]  data_q;
  meta_t [READ_LAT-1:0]       meta_q;
  logic                       err_q;

  assign size_s = funct3[1:0];
  assign idx_s  = addr[AW+1:2];

  // Reject illegal type, misalignment, out-of-range address, or read+write together.
  assign bad_s = (size_s == 2'b11) | (funct3 == 3'b110)
               | ((size_s == 2'b01) & addr[0])
               | ((size_s == 2'b10) & (addr[1:0] != 2'b00))
               | (|addr[31:AW+2])
               | (m_read & m_write);

  assign ld_acc_s = m_read & ~bad_s;
  // rst_n gate keeps the un-reset array from taking stores while in reset.
  assign st_acc_s = m_write & ~bad_s & rst_n;
  assign err_d    = (m_read | m_write) & bad_s;
  assign meta_d   = '{off: addr[1:0], size: size_s, uns: funct3[2]};

  // Byte-lane enables and lane-replicated store data
  always_comb begin
    be_s    = 4'b0000;
    wdata_s = 32'h0000_0000;
    case (size_s)
      2'b00: begin
        be_s    = 4'b0001 << addr[1:0];
        wdata_s = {4{d_in[7:0]}};
      end
      2'b01: begin
        be_s    = addr[1] ? 4'b1100 : 4'b0011;
        wdata_s = {2{d_in[15:0]}};
      end
      2'b10: begin
        be_s    = 4'b1111;
        wdata_s = d_in;
      end
      default: begin
        be_s    = 4'b0000;
        wdata_s = 32'h0000_0000;
      end
    endcase
  end

  // Storage array: byte-enable synchronous write, never reset
  always_ff @(posedge clk) begin
    if (st_acc_s) begin
      for (int i = 0; i < 4; i++) begin
        if (be_s[i]) begin
          mem_q[idx_s][8*i +: 8] <= wdata_s[8*i +: 8];
        end
      end
    end
  end

  // Load pipeline; stages only advance on valid so the last result is held
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q  <= '0;
      data_q <= '0;
      meta_q <= '0;
      err_q  <= 1'b0;
    end else begin
      err_q    <= err_d;
      vld_q[0] <= ld_acc_s;
      if (ld_acc_s) begin
        data_q[0] <= mem_q[idx_s];
        meta_q[0] <= meta_d;
      end
      for (int i = 1; i < READ_LAT; i++) begin
        vld_q[i] <= vld_q[i-1];
        if (vld_q[i-1]) begin
          data_q[i] <= data_q[i-1];
          meta_q[i] <= meta_q[i-1];
        end
      end
    end
  end

  assign d_out    = load_extend(data_q[READ_LAT-1], meta_q[READ_LAT-1]);
  assign rd_valid = vld_q[READ_LAT-1];
  assign err      = err_q;

endmodule
